// File: rtl/mp3_frame_sync_if.sv
`default_nettype none
// ============================================================================
//  Module   : mp3_frame_sync_if
//  Purpose  : Byte-stream input, payload output and decoded header fields
//             of the MP3 frame synchroniser. Statistics counters appear
//             only when MP3_FRAME_SYNC_STATS_EN is defined.
//  Revision : 1.0 - initial release
// ============================================================================
interface mp3_frame_sync_if;
    logic [7:0]  axiid;
    logic        axiiv;
    logic [7:0]  axiod;
    logic        axiov;
    logic        sof;
    logic        hdr_valid;
    logic        locked;
    logic        sync_lost;
    logic [1:0]  version;
    logic        prot;
    logic [8:0]  bitrate;
    logic [15:0] samp_rate;
    logic        padding;
    logic        private;
    logic [1:0]  mode;
    logic [1:0]  mode_ext;
    logic [1:0]  emphasis;
    logic [10:0] frame_sample;
    logic [10:0] frame_size;
`ifdef MP3_FRAME_SYNC_STATS_EN
    logic [15:0] frame_count;
    logic [7:0]  loss_count;
`endif

`ifdef MP3_FRAME_SYNC_STATS_EN
    modport master (
        output axiid, axiiv,
        input  axiod, axiov, sof, hdr_valid, locked, sync_lost, version, prot,
               bitrate, samp_rate, padding, private, mode, mode_ext, emphasis,
               frame_sample, frame_size, frame_count, loss_count
    );
    modport slave (
        input  axiid, axiiv,
        output axiod, axiov, sof, hdr_valid, locked, sync_lost, version, prot,
               bitrate, samp_rate, padding, private, mode, mode_ext, emphasis,
               frame_sample, frame_size, frame_count, loss_count
    );
`else
    modport master (
        output axiid, axiiv,
        input  axiod, axiov, sof, hdr_valid, locked, sync_lost, version, prot,
               bitrate, samp_rate, padding, private, mode, mode_ext, emphasis,
               frame_sample, frame_size
    );
    modport slave (
        input  axiid, axiiv,
        output axiod, axiov, sof, hdr_valid, locked, sync_lost, version, prot,
               bitrate, samp_rate, padding, private, mode, mode_ext, emphasis,
               frame_sample, frame_size
    );
`endif
endinterface
`default_nettype wire

// File: rtl/mp3_frame_sync.sv
`default_nettype none
// ============================================================================
//  Module   : mp3_frame_sync
//  Purpose  : Hunts a byte stream for MPEG audio Layer III headers, decodes
//             them, tracks frame boundaries and forwards locked payload.
//             Define MP3_FRAME_SYNC_STATS_EN to add frame/loss counters.
//  Revision : 1.0 - initial release
// ============================================================================
module mp3_frame_sync #(
    parameter int LOCK_FRAMES = 2,
    parameter int ALLOW_MPEG2 = 1
) (
    input  wire             clk,
    input  wire             rst,
    mp3_frame_sync_if.slave bus
);

    localparam logic [1:0] c_hunt    = 2'd0;
    localparam logic [1:0] c_payload = 2'd1;
    localparam logic [1:0] c_check   = 2'd2;
    localparam logic [3:0] c_lock    = 4'(LOCK_FRAMES);

    function automatic logic [8:0] f_bitrate(input logic mpeg1, input logic [3:0] idx);
        logic [8:0] v;
        v = 9'd0;
        if (mpeg1) begin
            case (idx)
                4'd1:  v = 9'd32;   4'd2:  v = 9'd40;   4'd3:  v = 9'd48;
                4'd4:  v = 9'd56;   4'd5:  v = 9'd64;   4'd6:  v = 9'd80;
                4'd7:  v = 9'd96;   4'd8:  v = 9'd112;  4'd9:  v = 9'd128;
                4'd10: v = 9'd160;  4'd11: v = 9'd192;  4'd12: v = 9'd224;
                4'd13: v = 9'd256;  4'd14: v = 9'd320;  default: v = 9'd0;
            endcase
        end else begin
            case (idx)
                4'd1:  v = 9'd8;    4'd2:  v = 9'd16;   4'd3:  v = 9'd24;
                4'd4:  v = 9'd32;   4'd5:  v = 9'd40;   4'd6:  v = 9'd48;
                4'd7:  v = 9'd56;   4'd8:  v = 9'd64;   4'd9:  v = 9'd80;
                4'd10: v = 9'd96;   4'd11: v = 9'd112;  4'd12: v = 9'd128;
                4'd13: v = 9'd144;  4'd14: v = 9'd160;  default: v = 9'd0;
            endcase
        end
        return v;
    endfunction

    function automatic logic [15:0] f_samp_rate(input logic [1:0] ver, input logic [1:0] idx);
        logic [15:0] v;
        case ({ver, idx})
            4'b11_00: v = 16'd44100;  4'b11_01: v = 16'd48000;  4'b11_10: v = 16'd32000;
            4'b10_00: v = 16'd22050;  4'b10_01: v = 16'd24000;  4'b10_10: v = 16'd16000;
            4'b00_00: v = 16'd11025;  4'b00_01: v = 16'd12000;  4'b00_10: v = 16'd8000;
            default:  v = 16'd0;
        endcase
        return v;
    endfunction

    // Only ever called with elaboration-time constants, so it folds to a ROM.
    function automatic logic [10:0] f_frame_bytes(input logic [7:0] key);
        int br;
        int sr;
        int k;
        int q;
        if (key[7:6] == 2'b01 || key[5:4] == 2'b11 || key[3:0] == 4'd0 || key[3:0] == 4'd15)
            return 11'd0;
        br = int'(f_bitrate(key[7:6] == 2'b11, key[3:0]));
        sr = int'(f_samp_rate(key[7:6], key[5:4]));
        k  = (key[7:6] == 2'b11) ? 144 : 72;
        q  = (k * br * 1000) / sr;
        return q[10:0];
    endfunction

    logic [10:0] w_fs_rom [0:255];

    generate
        for (genvar gi = 0; gi < 256; gi++) begin : g_fs_rom
            assign w_fs_rom[gi] = f_frame_bytes(8'(gi));
        end
    endgenerate

    logic [1:0]  r_state;
    logic [23:0] r_win;
    logic [2:0]  r_win_cnt;
    logic [3:0]  r_confirm;
    logic [10:0] r_pay_cnt;
    logic        r_first;
    logic [1:0]  r_sidx;
    logic [7:0]  r_axiod;
    logic        r_axiov, r_sof, r_hdr_valid, r_locked, r_sync_lost;
    logic [1:0]  r_version;
    logic        r_prot, r_padding, r_private;
    logic [8:0]  r_bitrate;
    logic [15:0] r_samp_rate;
    logic [1:0]  r_mode, r_mode_ext, r_emphasis;
    logic [10:0] r_frame_sample, r_frame_size;

    logic [31:0] w_win_next;
    logic [1:0]  w_ver, w_sidx;
    logic [3:0]  w_bidx;
    logic [2:0]  w_cnt_next;
    logic        w_full, w_hdr_ok, w_same, w_accept, w_reject;
    logic [10:0] w_frame_size;
    logic [3:0]  w_confirm_new;
    logic        w_unused_bits;

    assign w_win_next    = {r_win, bus.axiid};
    assign w_ver         = w_win_next[20:19];
    assign w_bidx        = w_win_next[15:12];
    assign w_sidx        = w_win_next[11:10];
    assign w_cnt_next    = (r_win_cnt == 3'd4) ? 3'd4 : r_win_cnt + 3'd1;
    assign w_full        = (w_cnt_next == 3'd4);
    assign w_hdr_ok      = (&w_win_next[31:21]) && (w_ver != 2'b01) &&
                           ((ALLOW_MPEG2 != 0) || (w_ver == 2'b11)) &&
                           (w_win_next[18:17] == 2'b01) &&
                           (w_bidx != 4'd0) && (w_bidx != 4'd15) && (w_sidx != 2'b11);
    // Layer is already pinned to III by w_hdr_ok, so only version/rate can drift.
    assign w_same        = (w_ver == r_version) && (w_sidx == r_sidx);
    assign w_accept      = bus.axiiv && w_full && w_hdr_ok &&
                           ((r_state == c_hunt) || ((r_state == c_check) && w_same));
    assign w_reject      = bus.axiiv && w_full && (r_state == c_check) && !(w_hdr_ok && w_same);
    assign w_frame_size  = w_fs_rom[{w_ver, w_sidx, w_bidx}] + {10'd0, w_win_next[9]};
    assign w_confirm_new = (r_state == c_hunt) ? 4'd1 :
                           (r_confirm == 4'hF) ? 4'hF : r_confirm + 4'd1;
    assign w_unused_bits = ^w_win_next[3:2];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= c_hunt;
            r_win          <= 24'd0;
            r_win_cnt      <= 3'd0;
            r_confirm      <= 4'd0;
            r_pay_cnt      <= 11'd0;
            r_first        <= 1'b0;
            r_sidx         <= 2'd0;
            r_axiod        <= 8'd0;
            r_axiov        <= 1'b0;
            r_sof          <= 1'b0;
            r_hdr_valid    <= 1'b0;
            r_locked       <= 1'b0;
            r_sync_lost    <= 1'b0;
            r_version      <= 2'd0;
            r_prot         <= 1'b0;
            r_bitrate      <= 9'd0;
            r_samp_rate    <= 16'd0;
            r_padding      <= 1'b0;
            r_private      <= 1'b0;
            r_mode         <= 2'd0;
            r_mode_ext     <= 2'd0;
            r_emphasis     <= 2'd0;
            r_frame_sample <= 11'd0;
            r_frame_size   <= 11'd0;
        end else begin
            r_axiov     <= 1'b0;
            r_sof       <= 1'b0;
            r_hdr_valid <= 1'b0;
            r_sync_lost <= 1'b0;
            if (bus.axiiv) begin
                case (r_state)
                    c_hunt, c_check: begin
                        r_win     <= w_win_next[23:0];
                        r_win_cnt <= w_cnt_next;
                    end
                    c_payload: begin
                        if (r_locked) begin
                            r_axiov <= 1'b1;
                            r_axiod <= bus.axiid;
                            r_sof   <= r_first;
                        end
                        r_first   <= 1'b0;
                        r_pay_cnt <= r_pay_cnt - 11'd1;
                        if (r_pay_cnt == 11'd1) begin
                            r_state   <= c_check;
                            r_win_cnt <= 3'd0;
                        end
                    end
                    default: r_state <= c_hunt;
                endcase
            end
            if (w_accept) begin
                r_hdr_valid    <= 1'b1;
                r_version      <= w_ver;
                r_sidx         <= w_sidx;
                r_prot         <= w_win_next[16];
                r_bitrate      <= f_bitrate(w_ver == 2'b11, w_bidx);
                r_samp_rate    <= f_samp_rate(w_ver, w_sidx);
                r_padding      <= w_win_next[9];
                r_private      <= w_win_next[8];
                r_mode         <= w_win_next[7:6];
                r_mode_ext     <= w_win_next[5:4];
                r_emphasis     <= w_win_next[1:0];
                r_frame_sample <= (w_ver == 2'b11) ? 11'd1152 : 11'd576;
                r_frame_size   <= w_frame_size;
                r_pay_cnt      <= w_frame_size - 11'd4;
                r_first        <= 1'b1;
                r_confirm      <= w_confirm_new;
                r_locked       <= r_locked | (w_confirm_new >= c_lock);
                r_state        <= c_payload;
            end else if (w_reject) begin
                // Window keeps its 4 bytes (count stays 4) so hunting slides on.
                r_sync_lost <= r_locked;
                r_locked    <= 1'b0;
                r_confirm   <= 4'd0;
                r_state     <= c_hunt;
            end
        end
    end

    assign bus.axiod        = r_axiod;
    assign bus.axiov        = r_axiov;
    assign bus.sof          = r_sof;
    assign bus.hdr_valid    = r_hdr_valid;
    assign bus.locked       = r_locked;
    assign bus.sync_lost    = r_sync_lost;
    assign bus.version      = r_version;
    assign bus.prot         = r_prot;
    assign bus.bitrate      = r_bitrate;
    assign bus.samp_rate    = r_samp_rate;
    assign bus.padding      = r_padding;
    assign bus.private      = r_private;
    assign bus.mode         = r_mode;
    assign bus.mode_ext     = r_mode_ext;
    assign bus.emphasis     = r_emphasis;
    assign bus.frame_sample = r_frame_sample;
    assign bus.frame_size   = r_frame_size;

`ifdef MP3_FRAME_SYNC_STATS_EN
    logic [15:0] r_frame_count;
    logic [7:0]  r_loss_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_frame_count <= 16'd0;
            r_loss_count  <= 8'd0;
        end else begin
            if (w_accept && (r_frame_count != 16'hFFFF))
                r_frame_count <= r_frame_count + 16'd1;
            if (w_reject && r_locked && (r_loss_count != 8'hFF))
                r_loss_count <= r_loss_count + 8'd1;
        end
    end

    assign bus.frame_count = r_frame_count;
    assign bus.loss_count  = r_loss_count;
`endif

endmodule
`default_nettype wire

// File: tb/tb_mp3_frame_sync.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mp3_frame_sync
//  Purpose  : Directed vector table plus lock / loss / reset sequences for
//             mp3_frame_sync (MPEG-2 enabled and MPEG-1-only instances).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_mp3_frame_sync;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mp3_frame_sync_if bus_a ();
    mp3_frame_sync_if bus_b ();

    mp3_frame_sync #(.LOCK_FRAMES(2), .ALLOW_MPEG2(1)) u_dut (.clk(clk), .rst(rst), .bus(bus_a));
    mp3_frame_sync #(.LOCK_FRAMES(2), .ALLOW_MPEG2(0)) u_dut_m1 (.clk(clk), .rst(rst), .bus(bus_b));

    assign bus_b.axiid = bus_a.axiid;
    assign bus_b.axiiv = bus_a.axiiv;

    typedef struct {
        logic [31:0] hdr;
        logic        ok_a;
        logic        ok_b;
        logic [1:0]  ver;
        int          br;
        int          sr;
        int          fs;
        int          fsamp;
        logic        pad;
        logic [1:0]  mode;
        logic [1:0]  mext;
        logic        prot;
    } vec_t;

    vec_t        vecs [9];
    int          n_checks = 0;
    int          n_errors = 0;
    int          n_hdr_a  = 0;
    int          n_hdr_b  = 0;
    int          n_lost_a = 0;
    logic [7:0]  rx_q [$];
    int          sof_q [$];
    logic        last_hv, last_lk, last_sl;

    always @(negedge clk) begin
        if (bus_a.hdr_valid) n_hdr_a++;
        if (bus_b.hdr_valid) n_hdr_b++;
        if (bus_a.sync_lost) n_lost_a++;
        if (bus_a.axiov) begin
            if (bus_a.sof) sof_q.push_back(rx_q.size());
            rx_q.push_back(bus_a.axiod);
        end
    end

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [127:0] outs_a();
        return {57'd0, bus_a.axiod, bus_a.axiov, bus_a.sof, bus_a.hdr_valid, bus_a.locked,
                bus_a.sync_lost, bus_a.version, bus_a.prot, bus_a.bitrate, bus_a.samp_rate,
                bus_a.padding, bus_a.private, bus_a.mode, bus_a.mode_ext, bus_a.emphasis,
                bus_a.frame_sample, bus_a.frame_size};
    endfunction

    function automatic logic [7:0] pay(input int i);
        return 8'((i * 7 + 3) & 255);
    endfunction

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        bus_a.axiid = b;
        bus_a.axiiv = 1'b1;
        step();
        bus_a.axiiv = 1'b0;
        last_hv = bus_a.hdr_valid;
        last_lk = bus_a.locked;
        last_sl = bus_a.sync_lost;
        repeat (gap) step();
    endtask

    task automatic send_word(input logic [31:0] w, input int gap);
        logic [31:0] t;
        t = w;
        for (int k = 0; k < 4; k++) begin
            send_byte(t[31:24], gap);
            t = t << 8;
        end
    endtask

    task automatic send_payload(input int n);
        for (int i = 0; i < n; i++) send_byte(pay(i), 0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus_a.axiiv = 1'b0;
        bus_a.axiid = 8'd0;
        step();
        step();
        rst = 1'b0;
        step();
    endtask

    initial begin
        int h0, hb0, l0, bad;
        rst = 1'b1;
        bus_a.axiiv = 1'b0;
        bus_a.axiid = 8'd0;
        step();
        do_reset();
        check("reset_outputs", outs_a(), 128'd0);

        vecs[0] = '{32'hFFFB9264, 1'b1, 1'b1, 2'b11, 128, 44100, 418, 1152, 1'b1, 2'b01, 2'b10, 1'b1};
        vecs[1] = '{32'hFFF39264, 1'b1, 1'b0, 2'b10, 80, 22050, 262, 576, 1'b1, 2'b01, 2'b10, 1'b1};
        vecs[2] = '{32'hFFFBF264, 1'b0, 1'b0, 2'b00, 0, 0, 0, 0, 1'b0, 2'b00, 2'b00, 1'b0};
        vecs[3] = '{32'hFFFB9C64, 1'b0, 1'b0, 2'b00, 0, 0, 0, 0, 1'b0, 2'b00, 2'b00, 1'b0};
        vecs[4] = '{32'hFFFD9264, 1'b0, 1'b0, 2'b00, 0, 0, 0, 0, 1'b0, 2'b00, 2'b00, 1'b0};
        vecs[5] = '{32'hFFFB0264, 1'b0, 1'b0, 2'b00, 0, 0, 0, 0, 1'b0, 2'b00, 2'b00, 1'b0};
        vecs[6] = '{32'hFFE3EA00, 1'b1, 1'b0, 2'b00, 160, 8000, 1441, 576, 1'b1, 2'b00, 2'b00, 1'b1};
        vecs[7] = '{32'hFFFAE8C0, 1'b1, 1'b1, 2'b11, 320, 32000, 1440, 1152, 1'b0, 2'b11, 2'b00, 1'b0};
        vecs[8] = '{32'hFFFB1430, 1'b1, 1'b1, 2'b11, 32, 48000, 96, 1152, 1'b0, 2'b00, 2'b11, 1'b1};

        for (int i = 0; i < 9; i++) begin
            do_reset();
            h0  = n_hdr_a;
            hb0 = n_hdr_b;
            send_word(vecs[i].hdr, 5);
            check($sformatf("v%0d_hv_cnt", i), 128'(n_hdr_a - h0), 128'(vecs[i].ok_a));
            check($sformatf("v%0d_hv_cnt_mpeg1only", i), 128'(n_hdr_b - hb0), 128'(vecs[i].ok_b));
            if (vecs[i].ok_a) begin
                check($sformatf("v%0d_version", i), bus_a.version, vecs[i].ver);
                check($sformatf("v%0d_bitrate", i), bus_a.bitrate, vecs[i].br);
                check($sformatf("v%0d_samp_rate", i), bus_a.samp_rate, vecs[i].sr);
                check($sformatf("v%0d_frame_size", i), bus_a.frame_size, vecs[i].fs);
                check($sformatf("v%0d_frame_sample", i), bus_a.frame_sample, vecs[i].fsamp);
                check($sformatf("v%0d_pad_mode_ext_prot", i),
                      {bus_a.padding, bus_a.mode, bus_a.mode_ext, bus_a.prot},
                      {vecs[i].pad, vecs[i].mode, vecs[i].mext, vecs[i].prot});
                check($sformatf("v%0d_locked", i), bus_a.locked, 1'b0);
            end
        end

        // hdr_valid must appear exactly one cycle after the final header byte
        do_reset();
        send_word(32'hFFFB9264, 0);
        check("hv_one_cycle_after", last_hv, 1'b1);

        do_reset();
        h0 = n_hdr_a;
        send_byte(8'h00, 1); send_byte(8'hFF, 1); send_byte(8'h12, 1);
        send_byte(8'hFF, 1); send_byte(8'hFB, 1); send_byte(8'h92, 1);
        send_byte(8'h64, 1);
        check("slide_hv_pulse", last_hv, 1'b1);
        check("slide_hv_cnt", 128'(n_hdr_a - h0), 128'd1);
        check("slide_frame_size", bus_a.frame_size, 11'd418);
        check("slide_samp_rate", bus_a.samp_rate, 16'd44100);

        do_reset();
        rx_q.delete();
        sof_q.delete();
        send_word(32'hFFFB9264, 0);
        send_payload(414);
        check("no_fwd_unlocked", 128'(rx_q.size()), 128'd0);
        check("unlocked_after_f1", bus_a.locked, 1'b0);
        send_word(32'hFFFB9264, 0);
        check("lock_hv", last_hv, 1'b1);
        check("lock_on_2nd", last_lk, 1'b1);
        send_payload(414);
        check("fwd_count", 128'(rx_q.size()), 128'd414);
        check("sof_count", 128'(sof_q.size()), 128'd1);
        if (sof_q.size() > 0) check("sof_first_byte", 128'(sof_q[0]), 128'd0);
        bad = 0;
        for (int i = 0; i < rx_q.size() && i < 414; i++) if (rx_q[i] !== pay(i)) bad++;
        check("fwd_data_errors", 128'(bad), 128'd0);

        h0 = n_hdr_a;
        l0 = n_lost_a;
        send_word(32'hFFFBF264, 0);
        check("loss_pulse", last_sl, 1'b1);
        check("loss_unlocked", last_lk, 1'b0);
        check("loss_no_hv", 128'(n_hdr_a - h0), 128'd0);
        check("loss_cnt", 128'(n_lost_a - l0), 128'd1);
        send_word(32'hFFFB9264, 0);
        check("recover_hv", last_hv, 1'b1);
        check("recover_not_locked", last_lk, 1'b0);
        send_payload(414);
        send_word(32'hFFFB9264, 0);
        check("relock", last_lk, 1'b1);
        send_payload(100);
        check("relock_fwd", bus_a.axiov, 1'b1);

        bus_a.axiid = 8'h55;
        bus_a.axiiv = 1'b1;
        rst = 1'b1;
        step();
        check("midreset_outputs", outs_a(), 128'd0);
        rst = 1'b0;
        bus_a.axiiv = 1'b0;
        step();
        send_word(32'hFFFB9264, 0);
        check("post_reset_hv", last_hv, 1'b1);
        check("post_reset_fs", bus_a.frame_size, 11'd418);
        check("post_reset_unlocked", bus_a.locked, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mp3_frame_sync.md
Name: mp3_frame_sync

Overview:
- Next-generation MP3 header block: hunts a raw byte stream for MPEG audio Layer III frame headers and decodes every header field.
- Computes frame length, then tracks frame boundaries by skipping payload and checking that the next header sits exactly frame_size bytes later.
- Declares lock after consecutive confirmations and forwards payload bytes of locked frames downstream.
- Sits between the byte-source and the side-info/bit-reservoir parser.

Parameters:
- LOCK_FRAMES, 2: consecutive valid headers at the predicted position needed to assert locked (1..15).
- ALLOW_MPEG2, 1: 1 accepts MPEG-2/2.5 headers in addition to MPEG-1; 0 accepts MPEG-1 only.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- axiid  in  8  input byte
- axiiv  in  1  input byte valid; no backpressure, a byte may arrive every cycle
- axiod  out  8  forwarded payload byte
- axiov  out  1  payload byte valid
- sof  out  1  high with the first payload byte of each forwarded frame
- hdr_valid  out  1  one-cycle pulse: header accepted, field outputs updated
- locked  out  1  stream locked
- sync_lost  out  1  one-cycle pulse: locked and expected header failed
- version  out  2  11 = MPEG-1, 10 = MPEG-2, 00 = MPEG-2.5
- prot  out  1  protection bit (0 = CRC present)
- bitrate  out  9  kbps
- samp_rate  out  16  Hz
- padding, private  out  1 each
- mode, mode_ext, emphasis  out  2 each
- frame_sample  out  11  1152 for MPEG-1, 576 otherwise
- frame_size  out  11  total frame bytes including header

Behaviour:
- Reset: all outputs 0; state HUNT; window count 0; confirm count 0.
- rst wins over any concurrent axiiv.
- Header validity, over a 32-bit big-endian window:
  - sync [31:21] all ones
  - version != 01, and version == 11 when ALLOW_MPEG2 == 0
  - layer [18:17] == 01
  - bitrate index [15:12] not 0 (free format rejected) and not 15
  - samp index [11:10] != 3
- Bitrate tables:
  - MPEG-1: 32,40,48,56,64,80,96,112,128,160,192,224,256,320
  - MPEG-2/2.5: 8,16,24,32,40,48,56,64,80,96,112,128,144,160
- Sample-rate tables:
  - MPEG-1: 44100, 48000, 32000
  - MPEG-2: 22050, 24000, 16000
  - MPEG-2.5: 11025, 12000, 8000
- frame_size = floor(K*bitrate*1000/samp_rate) + padding, with K = 144 (MPEG-1) or 72 (MPEG-2/2.5).
  - Implemented as a case table; no runtime divider.
  - Maximum value 1441 fits 11 bits.
- HUNT:
  - Each accepted byte shifts into a 4-byte window; window count saturates at 4.
  - When count == 4 and the window is valid: go to PAYLOAD, pulse hdr_valid the cycle after the 4th byte, register all fields, confirm = 1.
  - Invalid window: keep sliding byte by byte.
- PAYLOAD:
  - Counts frame_size-4 bytes.
  - Forwards each byte on axiod/axiov one cycle after acceptance, only while locked; sof accompanies the first.
  - CRC bytes (prot = 0) are forwarded as payload.
  - After the last byte, go to CHECK.
- CHECK:
  - Collects 4 bytes.
  - Valid, with version, layer and samp index equal to the previous header: hdr_valid, fields updated, confirm saturating-increments, go to PAYLOAD.
  - locked sets on the hdr_valid cycle where confirm reaches LOCK_FRAMES; payload of that frame is forwarded.
  - Otherwise: if locked, pulse sync_lost; clear locked and confirm; return to HUNT with the 4 bytes kept in the window (count = 4) so sliding resumes.
- axiiv low: no state change; idle gaps of any length are allowed.

Optional Feature:
- Macro MP3_FRAME_SYNC_STATS_EN.
- Defined: adds outputs frame_count[15:0] (increments per hdr_valid) and loss_count[7:0] (increments per sync_lost). Both saturate at all ones and reset to 0.
- Undefined: ports and counters absent; all other behaviour identical.

Test Plan:
- Reset, then bytes FF FB 92 64 spaced 6 cycles apart:
  - hdr_valid one cycle after 64
  - version 11, bitrate 128, samp_rate 44100, padding 1, mode 01, mode_ext 10, prot 1
  - frame_size 418, frame_sample 1152, locked 0
- Bytes 00 FF 12 FF FB 92 64 -> exactly one hdr_valid, after the final 64; same fields as above.
- Two back-to-back 418-byte frames headed FFFB9264, LOCK_FRAMES = 2:
  - second hdr_valid raises locked
  - frame 2 payload of 414 bytes appears on axiod, sof on the first
  - no axiov during frame 1
- Locked stream whose next header is FF FB F2 64 -> sync_lost pulse, locked 0, no hdr_valid, then the hunt recovers on a following FFFB9264.
- Rejections: FFFBF264, FFFB9C64, FFFD9264, FFFB0264 produce no hdr_valid.
  - FFF39264 gives version 10, bitrate 80, samp_rate 22050, frame_size 262, frame_sample 576.
  - With ALLOW_MPEG2 = 0, FFF39264 is rejected.
- rst asserted mid-payload -> next cycle: all outputs 0, state HUNT; a fresh FFFB9264 is accepted normally.
